// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ready handshake
// into a 2-entry queue, and flushes/redirects on taken branches and jumps.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] Instruction,
  output logic [31:0] PC_Plus4,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [1:0]  r_count;
  logic [1:0]  w_nextCount;
  logic        r_head;
  logic [31:0] r_fetchPc;
  logic [31:0] w_nextFetchPc;
  logic [31:0] r_reqAddr;
  logic [31:0] w_nextReqAddr;
  logic [31:0] r_qInstr [2];
  logic [31:0] r_qPc4   [2];

  logic        w_pop;
  logic        w_push;
  logic        w_tail;
  logic [1:0]  w_countAfterPop;
  logic [31:0] w_target;
  logic [31:0] w_fetchPcPlus4;
  logic        w_unusedLowBits;

  assign w_target        = {redirect_pc[31:2], 2'b00};
  assign w_unusedLowBits = ^redirect_pc[1:0];
  assign w_fetchPcPlus4  = r_fetchPc + 32'd4;

  assign instr_valid = (r_count != 2'd0);
  assign Instruction = instr_valid ? r_qInstr[r_head] : NOP_INSTR;
  assign PC_Plus4    = instr_valid ? r_qPc4[r_head] : 32'd0;

  // A redirect flushes the queue, so the head is never consumed that cycle.
  assign w_pop           = instr_valid && !stall && !redirect;
  assign w_countAfterPop = r_count - {1'b0, w_pop};
  assign w_tail          = r_head ^ r_count[0];

  assign imem_req  = (r_state == WAIT) || (r_state == DRAIN);
  assign imem_addr = (r_state == DRAIN) ? r_reqAddr : r_fetchPc;

  always_comb begin
    w_nextState   = r_state;
    w_nextCount   = w_countAfterPop;
    w_nextFetchPc = r_fetchPc;
    w_nextReqAddr = r_reqAddr;
    w_push        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (redirect) begin
          w_nextCount   = 2'd0;
          w_nextFetchPc = w_target;
        end else if (w_countAfterPop != 2'd2) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          w_nextCount   = 2'd0;
          w_nextFetchPc = w_target;
          if (imem_ready) begin
            w_nextState = IDLE;
          end else begin
            // fetch_pc now holds the target, so remember the in-flight address
            w_nextState   = DRAIN;
            w_nextReqAddr = r_fetchPc;
          end
        end else if (imem_ready) begin
          w_push        = 1'b1;
          w_nextCount   = w_countAfterPop + 2'd1;
          w_nextFetchPc = w_fetchPcPlus4;
          w_nextState   = (w_countAfterPop == 2'd0) ? WAIT : IDLE;
        end
      end
      DRAIN: begin
        if (redirect) begin
          w_nextCount   = 2'd0;
          w_nextFetchPc = w_target;
        end
        if (imem_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= 2'd0;
      r_head    <= 1'b0;
      r_fetchPc <= RESET_PC;
      r_reqAddr <= RESET_PC;
    end else begin
      r_state   <= w_nextState;
      r_count   <= w_nextCount;
      r_head    <= r_head ^ w_pop;
      r_fetchPc <= w_nextFetchPc;
      r_reqAddr <= w_nextReqAddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_qInstr[0] <= 32'd0;
      r_qInstr[1] <= 32'd0;
      r_qPc4[0]   <= 32'd0;
      r_qPc4[1]   <= 32'd0;
    end else if (w_push) begin
      r_qInstr[w_tail] <= imem_rdata;
      r_qPc4[w_tail]   <= w_fetchPcPlus4;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a queue-level reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] Instruction;
  logic [31:0] PC_Plus4;
  logic        instr_valid;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .Instruction(Instruction),
    .PC_Plus4   (PC_Plus4),
    .instr_valid(instr_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  bit          tbReset    = 1'b1;
  bit          tbStall    = 1'b0;
  bit          tbRedirect = 1'b0;
  logic [31:0] tbRedirectPc = 32'd0;
  int          memLatency = 0;
  int          memWaitCnt = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  // Reference model: the fetched-word queue, the PC, and whether a request
  // (possibly a stale one whose data must be thrown away) is in flight.
  entry_t      mq[$];
  logic [31:0] mFetchPc    = RESET_PC;
  logic [31:0] mReqAddr    = RESET_PC;
  bit          mOutstanding = 1'b0;
  bit          mStale       = 1'b0;
  bit          modelReady   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout expected=event at %0t", name, $time);
  endtask

  task automatic stepModel(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                           input bit rdy, input logic [31:0] rdata);
    entry_t e;
    if (rst) begin
      mq.delete();
      mFetchPc     = RESET_PC;
      mReqAddr     = RESET_PC;
      mOutstanding = 1'b0;
      mStale       = 1'b0;
      return;
    end
    if (rd) begin
      mq.delete();
      mFetchPc = {rpc[31:2], 2'b00};
      if (mOutstanding) begin
        if (rdy) begin
          mOutstanding = 1'b0;
          mStale       = 1'b0;
        end else begin
          mStale = 1'b1;
        end
      end
    end else begin
      if (mq.size() != 0 && !st) void'(mq.pop_front());
      if (mOutstanding) begin
        if (rdy) begin
          if (mStale) begin
            mOutstanding = 1'b0;
            mStale       = 1'b0;
          end else begin
            e.instr = rdata;
            e.pc4   = mFetchPc + 32'd4;
            mq.push_back(e);
            mFetchPc     = mFetchPc + 32'd4;
            mOutstanding = (mq.size() < 2);
            mReqAddr     = mFetchPc;
          end
        end
      end else if (mq.size() < 2) begin
        mOutstanding = 1'b1;
        mReqAddr     = mFetchPc;
      end
    end
  endtask

  // Per-cycle compare, then drive inputs and emulate a variable-latency memory.
  initial begin
    logic [31:0] expAddr;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_ready  = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      if (modelReady) begin
        expAddr = mOutstanding ? mReqAddr : mFetchPc;
        checkOutput("imem_req", {31'd0, imem_req}, {31'd0, mOutstanding});
        checkOutput("imem_addr", imem_addr, expAddr);
        checkOutput("instr_valid", {31'd0, instr_valid}, {31'd0, (mq.size() != 0)});
        if (mq.size() != 0) begin
          checkOutput("Instruction", Instruction, mq[0].instr);
          checkOutput("PC_Plus4", PC_Plus4, mq[0].pc4);
        end else begin
          checkOutput("Instruction", Instruction, NOP);
          checkOutput("PC_Plus4", PC_Plus4, 32'd0);
        end
      end
      reset       = tbReset;
      stall       = tbStall;
      redirect    = tbRedirect;
      redirect_pc = tbRedirectPc;
      if (tbReset) begin
        imem_ready = 1'b0;
        memWaitCnt = 0;
      end else begin
        imem_ready = imem_req && (memWaitCnt >= memLatency);
        memWaitCnt = (imem_ready || !imem_req) ? 0 : memWaitCnt + 1;
      end
      imem_rdata = imem_ready ? (imem_addr ^ XOR_KEY) : 32'hDEAD_BEEF;
      stepModel(tbReset, tbStall, tbRedirect, tbRedirectPc, imem_ready, imem_rdata);
      modelReady = 1'b1;
    end
  end

  task automatic applyStimulus(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                               input int cycles);
    tbReset      = rst;
    tbStall      = st;
    tbRedirect   = rd;
    tbRedirectPc = rpc;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitValid(input string name, input int maxCycles);
    bit found = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1);
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) reportTimeout(name);
  endtask

  task automatic waitMidLatency(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && memWaitCnt == 1) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1);
    end
    if (!found) reportTimeout(name);
  endtask

  initial begin
    int  pulses;
    bit  seen;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("reset req", {31'd0, imem_req}, 32'd0);
    checkOutput("reset valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("reset instr", Instruction, NOP);
    checkOutput("reset pc4", PC_Plus4, 32'd0);
    checkOutput("reset addr", imem_addr, RESET_PC);

    // zero-wait streaming
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 2);
    checkOutput("first instr", Instruction, 32'hA5A5_0000);
    checkOutput("first pc4", PC_Plus4, 32'h0000_0004);
    checkOutput("first addr", imem_addr, 32'h0000_0004);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1);
    checkOutput("second instr", Instruction, 32'hA5A5_0004);
    checkOutput("second pc4", PC_Plus4, 32'h0000_0008);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 3);
    checkOutput("head before stall", Instruction, 32'hA5A5_0010);

    // stall with queue filling
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 5);
    checkOutput("stall req drops", {31'd0, imem_req}, 32'd0);
    checkOutput("stall head held", Instruction, 32'hA5A5_0010);
    checkOutput("stall pc4 held", PC_Plus4, 32'h0000_0014);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1);
    checkOutput("release word 2", Instruction, 32'hA5A5_0014);
    checkOutput("release next addr", imem_addr, 32'h0000_0018);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1);
    checkOutput("release word 3", Instruction, 32'hA5A5_0018);
    checkOutput("release pc4 3", PC_Plus4, 32'h0000_001C);

    // 3-cycle memory latency: one valid per 4 cycles
    memLatency = 3;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 8);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1);
      if (instr_valid) pulses++;
    end
    checkOutput("latency valid pulses", pulses, 32'd4);

    // redirect mid-latency: flush, drain stale response, fetch target
    waitMidLatency("mid-latency wait 1");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1);
    checkOutput("redirect flush valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("drain req held", {31'd0, imem_req}, 32'd1);
    waitValid("redirect target valid", 30);
    checkOutput("redirect pc4", PC_Plus4, 32'h0000_0104);
    checkOutput("redirect instr", Instruction, 32'hA5A5_0100);

    // redirect with ready and stall in the same cycle
    memLatency = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1);
    checkOutput("redir+ready valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("redir+ready req", {31'd0, imem_req}, 32'd0);
    waitValid("redir+ready target valid", 10);
    checkOutput("redir+ready pc4", PC_Plus4, 32'h0000_0204);
    checkOutput("redir+ready instr", Instruction, 32'hA5A5_0200);

    // PC wrap
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1);
    waitValid("wrap valid", 10);
    checkOutput("wrap pc4", PC_Plus4, 32'h0000_0000);
    checkOutput("wrap instr", Instruction, 32'h5A5A_FFFC);
    checkOutput("wrap next addr", imem_addr, 32'h0000_0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1);
    checkOutput("after wrap pc4", PC_Plus4, 32'h0000_0004);
    checkOutput("after wrap instr", Instruction, 32'hA5A5_0000);

    // reset while draining a stale request
    memLatency = 3;
    waitMidLatency("mid-latency wait 2");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1);
    checkOutput("drain before reset req", {31'd0, imem_req}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1);
    checkOutput("drain reset req", {31'd0, imem_req}, 32'd0);
    checkOutput("drain reset valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("drain reset instr", Instruction, NOP);
    checkOutput("drain reset pc4", PC_Plus4, 32'd0);
    checkOutput("drain reset addr", imem_addr, RESET_PC);
    memLatency = 0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1);
      if (imem_req) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportTimeout("post-reset request");
    checkOutput("post-reset addr", imem_addr, RESET_PC);
    waitValid("post-reset valid", 10);
    checkOutput("post-reset pc4", PC_Plus4, 32'h0000_0004);
    checkOutput("post-reset instr", Instruction, 32'hA5A5_0000);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle CS3421_RRK_Processor datapath and produces the `Instruction` and `PC_Plus4` values that the datapath consumes.
- Owns the program counter and talks to instruction memory over a req/ready handshake, so memory latency is variable.
- Buffers fetched words in a 2-entry queue, so downstream stalls do not drop instructions.
- Handles branch/jump redirects by flushing the queue and discarding the in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- NOP_INSTR, 32'h0000_0000, value driven on `Instruction` when the queue is empty.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  request to instruction memory; held high until imem_ready.
- imem_addr  out  32  word address of the current request; stable while imem_req=1.
- imem_ready  in  1  response valid this cycle; completes the outstanding request.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- redirect  in  1  taken branch/jump from the datapath (PC_Src or Jump).
- redirect_pc  in  32  target address; bits [1:0] are ignored (forced to 00).
- stall  in  1  downstream cannot accept the head instruction this cycle.
- Instruction  out  32  head-of-queue instruction, or NOP_INSTR when empty.
- PC_Plus4  out  32  address of the head instruction + 4; 0 when empty.
- instr_valid  out  1  queue non-empty.

Behaviour:
- Reset: this is one clock domain, and reset is synchronous and active-high on clk; reset has priority over every other input.
  - After the reset edge: state=IDLE, count=0, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, Instruction=NOP_INSTR, PC_Plus4=0.
  - Reset mid-request abandons the memory transaction; the memory is reset by the same signal.
- Queue: 2 entries of {instr[31:0], pc_plus4[31:0]}, with a count of 0..2.
  - Outputs are combinational from the head entry.
  - Pop condition: instr_valid && !stall.
  - Push: the response in WAIT state with no redirect.
  - Push and pop in the same cycle leave the count unchanged.
  - A request is never issued at count=2, so overflow is impossible.
- At most one memory request is outstanding.
  - imem_req=1 exactly in WAIT and DRAIN; imem_addr = fetch_pc.
- State IDLE: if redirect=1, set fetch_pc <= {redirect_pc[31:2],2'b00} and stay in IDLE. Otherwise, if count<2 after this cycle's pop, go to WAIT.
- State WAIT:
  - redirect=1: flush (count<=0), set fetch_pc <= target. Go to DRAIN if imem_ready=0; if imem_ready=1, discard the response and go to IDLE.
  - imem_ready=1 and no redirect: push {imem_rdata, fetch_pc+4} and set fetch_pc <= fetch_pc+4. Stay in WAIT if the resulting count <2; otherwise go to IDLE.
  - Otherwise hold: address stable, imem_req high.
- State DRAIN (stale request in flight):
  - imem_req stays high, with imem_addr still the old address until completion. Note: fetch_pc already holds the target, so implement a separate req_addr register.
  - On imem_ready, discard the data and go to IDLE.
  - A further redirect overwrites the target.
  - instr_valid=0 throughout.
- Redirect beats stall and beats imem_ready in the same cycle.
  - The queue empties at that edge, so the instruction on the outputs that cycle is not considered consumed by the fetch unit.
- Throughput: one instruction per cycle when imem_ready is held high and stall=0.
  - First instr_valid appears two edges after a request is issued with zero-wait memory: one edge IDLE->WAIT, then one edge for the response.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 0.

Test Plan:
- Reset, then memory with imem_ready=1 every cycle returning word = addr^32'hA5A5_0000, stall=0.
  - Required: addresses issued 0,4,8,C…
  - Outputs: Instruction sequence A5A5_0000, A5A5_0004…
  - PC_Plus4 = 4, 8, C…; one valid per cycle.
- stall=1 for 5 cycles, memory always ready.
  - Exactly 2 words are queued and imem_req drops.
  - On release, the words emerge in order with no loss or duplication: 0x10, 0x14, then 0x18.
- Memory latency of 3 cycles.
  - imem_addr stays stable while imem_req is high.
  - instr_valid pulses once per completed request.
- redirect=1, redirect_pc=32'h0000_0103 while WAIT is mid-latency.
  - Queue flushes and instr_valid=0.
  - The stale response is discarded.
  - The next request goes to 32'h0000_0100, and the output shows PC_Plus4=0x104.
- redirect with imem_ready=1 in the same cycle.
  - The response is not pushed, and the next fetch is the target.
  - redirect together with stall=1: the target still wins.
- fetch_pc=32'hFFFF_FFFC by redirect.
  - Output PC_Plus4=0, and the next address is 0.
  - Assert reset during DRAIN: all outputs take their reset values and the next request goes to RESET_PC.
